// File: rtl/exec_pkg.sv
// Shared opcodes, function codes, ALU control encodings and the decode bundle
// for the decode/execute/memory slice.
package exec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b100;

    typedef struct packed {
        logic [2:0] aluc;
        logic       reg_write;
        logic       reg_dst_rt;
        logic       alu_src_imm;
        logic       mem_to_reg;
        logic       mem_write;
        logic       is_beq;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// 32-bit ALU: add/sub/and/or/signed slt; unused codes yield zero.
module exec_alu
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  aluc,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (aluc)
            ALUC_ADD: result = a + b;
            ALUC_SUB: result = a - b;
            ALUC_AND: result = a & b;
            ALUC_OR:  result = a | b;
            ALUC_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/exec_mem_unit.sv
// Decode, ALU and word-addressed data memory of the single-cycle CPU.
// Everything is combinational except the memory write.
module exec_mem_unit
    import exec_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm_ext,
    output logic [2:0]  aluc,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_data,
    output logic        reg_write,
    output logic        reg_dst_rt,
    output logic        alu_src_imm,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        branch,
    output logic        jump
);

    localparam int IDX_W = $clog2(DEPTH);

    ctrl_t              ctrl;
    logic [31:0]        alu_b;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];
    logic               unused_addr;

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case (func)
                    FUNC_ADD: ctrl.aluc = ALUC_ADD;
                    FUNC_SUB: ctrl.aluc = ALUC_SUB;
                    FUNC_AND: ctrl.aluc = ALUC_AND;
                    FUNC_OR:  ctrl.aluc = ALUC_OR;
                    FUNC_SLT: ctrl.aluc = ALUC_SLT;
                    default:  ctrl.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                ctrl.aluc        = (op == OP_ANDI) ? ALUC_AND :
                                   (op == OP_ORI)  ? ALUC_OR  : ALUC_ADD;
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst_rt  = 1'b1;
                ctrl.alu_src_imm = 1'b1;
            end
            OP_LW: begin
                ctrl.aluc        = ALUC_ADD;
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst_rt  = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.aluc        = ALUC_ADD;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.aluc   = ALUC_SUB;
                ctrl.is_beq = 1'b1;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_data;

    exec_alu u_alu (
        .a      (rs_data),
        .b      (alu_b),
        .aluc   (ctrl.aluc),
        .result (alu_result),
        .zero   (zero)
    );

    // Byte offset and bits above the index are dropped, so addresses wrap.
    assign idx         = alu_result[IDX_W+1:2];
    assign unused_addr = ^{alu_result[31:IDX_W+2], alu_result[1:0]};

    always_comb begin
        mem_d = mem_q;
        if (ctrl.mem_write) mem_d[idx] = rt_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign mem_rdata   = mem_q[idx];
    assign wb_data     = ctrl.mem_to_reg ? mem_rdata : alu_result;
    assign aluc        = ctrl.aluc;
    assign reg_write   = ctrl.reg_write;
    assign reg_dst_rt  = ctrl.reg_dst_rt;
    assign alu_src_imm = ctrl.alu_src_imm;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign mem_write   = ctrl.mem_write;
    assign branch      = ctrl.is_beq & zero;
    assign jump        = ctrl.jump;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit with hand-computed expectations.
module tb_exec_mem_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [2:0]  aluc;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;
    logic        reg_write;
    logic        reg_dst_rt;
    logic        alu_src_imm;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;

    int vectors;
    int miscompares;

    exec_mem_unit #(.DEPTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .func        (func),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .aluc        (aluc),
        .alu_result  (alu_result),
        .zero        (zero),
        .mem_rdata   (mem_rdata),
        .wb_data     (wb_data),
        .reg_write   (reg_write),
        .reg_dst_rt  (reg_dst_rt),
        .alu_src_imm (alu_src_imm),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [5:0] o, input logic [5:0] f,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm);
        op = o; func = f; rs_data = rs; rt_data = rt; imm_ext = imm;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(6'b100011, 6'd0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if (mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata0 got %h want %h", mem_rdata, 32'h0);
        end
        apply(6'b100011, 6'd0, 32'h40, 32'h0, 32'h3C);
        vectors++;
        if (mem_rdata !== 32'h0 || wb_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata7c got %h/%h want 0/0", mem_rdata, wb_data);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_r_add();
        apply(6'b000000, 6'b100000, 32'd7, 32'd5, 32'h0);
        vectors++;
        if (alu_result !== 32'd12 || reg_write !== 1'b1 || reg_dst_rt !== 1'b0 ||
            wb_data !== 32'd12 || aluc !== 3'b000 || alu_src_imm !== 1'b0) begin
            miscompares++;
            $display("FAIL r_add got res=%h rw=%b rd=%b wb=%h aluc=%b imm=%b want 0000000c 1 0 0000000c 000 0",
                     alu_result, reg_write, reg_dst_rt, wb_data, aluc, alu_src_imm);
        end
    endtask

    task automatic test_r_ops();
        apply(6'b000000, 6'b100010, 32'd5, 32'd7, 32'h0);
        vectors++;
        if (alu_result !== 32'hFFFF_FFFE || aluc !== 3'b001) begin
            miscompares++;
            $display("FAIL r_sub got %h/%b want fffffffe/001", alu_result, aluc);
        end
        apply(6'b000000, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0);
        vectors++;
        if (alu_result !== 32'h00F0_1200 || aluc !== 3'b010) begin
            miscompares++;
            $display("FAIL r_and got %h/%b want 00f01200/010", alu_result, aluc);
        end
        apply(6'b000000, 6'b100101, 32'hF000_0001, 32'h0000_0F00, 32'h0);
        vectors++;
        if (alu_result !== 32'hF000_0F01 || aluc !== 3'b011) begin
            miscompares++;
            $display("FAIL r_or got %h/%b want f0000f01/011", alu_result, aluc);
        end
        apply(6'b000000, 6'b111111, 32'd1, 32'd2, 32'h0);
        vectors++;
        if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL r_unknown_func got rw=%b mw=%b want 0 0", reg_write, mem_write);
        end
    endtask

    task automatic test_beq();
        apply(6'b000100, 6'd0, 32'h1234, 32'h1234, 32'h7);
        vectors++;
        if (aluc !== 3'b001 || zero !== 1'b1 || branch !== 1'b1 || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_taken got aluc=%b z=%b br=%b rw=%b want 001 1 1 0",
                     aluc, zero, branch, reg_write);
        end
        apply(6'b000100, 6'd0, 32'h1234, 32'h1235, 32'h7);
        vectors++;
        if (branch !== 1'b0 || zero !== 1'b0 || alu_result !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL beq_not_taken got br=%b z=%b res=%h want 0 0 ffffffff",
                     branch, zero, alu_result);
        end
        apply(6'b000000, 6'b100010, 32'h55, 32'h55, 32'h0);
        vectors++;
        if (zero !== 1'b1 || branch !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_zero_no_branch got z=%b br=%b want 1 0", zero, branch);
        end
    endtask

    task automatic test_slt();
        apply(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0);
        vectors++;
        if (alu_result !== 32'd1 || aluc !== 3'b100) begin
            miscompares++;
            $display("FAIL slt_neg got %h/%b want 00000001/100", alu_result, aluc);
        end
        apply(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h0);
        vectors++;
        if (alu_result !== 32'd0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL slt_swap got %h z=%b want 00000000 1", alu_result, zero);
        end
    endtask

    task automatic test_imm();
        apply(6'b001000, 6'd0, 32'd10, 32'hDEAD, 32'hFFFF_FFFD);
        vectors++;
        if (alu_result !== 32'd7 || reg_dst_rt !== 1'b1 || alu_src_imm !== 1'b1 ||
            reg_write !== 1'b1) begin
            miscompares++;
            $display("FAIL addi got res=%h rd=%b imm=%b rw=%b want 00000007 1 1 1",
                     alu_result, reg_dst_rt, alu_src_imm, reg_write);
        end
        apply(6'b001100, 6'd0, 32'hFFFF_0F0F, 32'h0, 32'hFFFF_8001);
        vectors++;
        if (alu_result !== 32'hFFFF_0001 || aluc !== 3'b010) begin
            miscompares++;
            $display("FAIL andi got %h/%b want ffff0001/010", alu_result, aluc);
        end
        apply(6'b001101, 6'd0, 32'h0000_0010, 32'h0, 32'hFFFF_8000);
        vectors++;
        if (alu_result !== 32'hFFFF_8010 || aluc !== 3'b011) begin
            miscompares++;
            $display("FAIL ori got %h/%b want ffff8010/011", alu_result, aluc);
        end
    endtask

    task automatic test_sw_lw();
        apply(6'b101011, 6'd0, 32'h10, 32'hDEAD_BEEF, 32'h4);
        vectors++;
        if (mem_write !== 1'b1 || reg_write !== 1'b0 || alu_result !== 32'h14) begin
            miscompares++;
            $display("FAIL sw_ctrl got mw=%b rw=%b addr=%h want 1 0 00000014",
                     mem_write, reg_write, alu_result);
        end
        @(posedge clk);
        #1;
        apply(6'b100011, 6'd0, 32'h10, 32'h0, 32'h4);
        vectors++;
        if (mem_rdata !== 32'hDEAD_BEEF || wb_data !== 32'hDEAD_BEEF || mem_to_reg !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_same got rd=%h wb=%h m2r=%b want deadbeef deadbeef 1",
                     mem_rdata, wb_data, mem_to_reg);
        end
        apply(6'b100011, 6'd0, 32'h11, 32'h0, 32'h4);
        vectors++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lw_alias15 got %h want deadbeef", mem_rdata);
        end
        apply(6'b100011, 6'd0, 32'h90, 32'h0, 32'h4);
        vectors++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL lw_wrap94 got %h want deadbeef", mem_rdata);
        end
        apply(6'b100011, 6'd0, 32'h18, 32'h0, 32'h0);
        vectors++;
        if (mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL lw_neighbour got %h want 00000000", mem_rdata);
        end
    endtask

    task automatic test_jump_unknown();
        apply(6'b000010, 6'd0, 32'd3, 32'd3, 32'h0);
        vectors++;
        if (jump !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0 || branch !== 1'b0) begin
            miscompares++;
            $display("FAIL jump got j=%b rw=%b mw=%b br=%b want 1 0 0 0",
                     jump, reg_write, mem_write, branch);
        end
        apply(6'b111111, 6'b100000, 32'd3, 32'd3, 32'h0);
        vectors++;
        if (reg_write !== 1'b0 || mem_write !== 1'b0 || branch !== 1'b0 ||
            jump !== 1'b0 || aluc !== 3'b000 || mem_to_reg !== 1'b0) begin
            miscompares++;
            $display("FAIL unknown_op got rw=%b mw=%b br=%b j=%b aluc=%b m2r=%b want 0 0 0 0 000 0",
                     reg_write, mem_write, branch, jump, aluc, mem_to_reg);
        end
    endtask

    task automatic test_reset_mid();
        apply(6'b101011, 6'd0, 32'h8, 32'h0000_CAFE, 32'h0);
        @(posedge clk);
        #1;
        apply(6'b100011, 6'd0, 32'h8, 32'h0, 32'h0);
        vectors++;
        if (mem_rdata !== 32'h0000_CAFE) begin
            miscompares++;
            $display("FAIL store8 got %h want 0000cafe", mem_rdata);
        end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_rdata !== 32'h0 || wb_data !== 32'h0) begin
            miscompares++;
            $display("FAIL async_clear8 got %h/%h want 0/0", mem_rdata, wb_data);
        end
        apply(6'b100011, 6'd0, 32'h14, 32'h0, 32'h0);
        vectors++;
        if (mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_clear14 got %h want 00000000", mem_rdata);
        end
        apply(6'b101011, 6'd0, 32'hC, 32'h1111_2222, 32'h0);
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL ctrl_in_reset got mw=%b want 1", mem_write);
        end
        @(posedge clk);
        #1;
        apply(6'b100011, 6'd0, 32'hC, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_in_reset got %h want 00000000", mem_rdata);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        op = '0; func = '0; rs_data = '0; rt_data = '0; imm_ext = '0;
        test_reset();
        test_r_add();
        test_r_ops();
        test_beq();
        test_slt();
        test_imm();
        test_sw_lw();
        test_jump_unknown();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
